bound_flasher_monitor: RTL
==========================

// Module: bound_flasher_monitor
// PURPOSE
//  Receive-side decoder/checker for the 16-LED bound-flasher bus. Samples LED[15:0] every clk,
//  converts it to a lit-count level and tracks the 6-phase bounce sequence.
//  Reports phase, direction, start/done/kickback events and protocol errors.
//  Sits beside the flasher (or on a board-level LED tap); used in system status logic and benches.
// PARAMETERS
//  WIDTH    16  LED bus width; LW = $clog2(WIDTH+1) level bits
//  PEAK0    16  required up-reversal level, phase 0
//  TROUGH1   6  required down-reversal level, phase 1 (troughs of phases 3 and 5 fixed at 0)
//  PEAK2    11  required up-reversal level, phase 2
//  PEAK4     6  required up-reversal level, phase 4
//  KICK_LVL  6  only legal early-reversal (kickback) level in phase 3
//  CNT_W     8  width of seq_cnt / err_cnt (saturating)
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      synchronous, active-low reset
//  LED       in   WIDTH  observed flasher bus
//  level     out  LW     lit count of last sample
//  phase     out  3      current phase 0..5 (0 when idle)
//  dir_up    out  1      1 = rising phase
//  busy      out  1      sequence in progress
//  start_p   out  1      1-cycle pulse: sequence started
//  done_p    out  1      1-cycle pulse: phase 5 reached 0
//  kick_p    out  1      1-cycle pulse: kickback decoded
//  err_p     out  1      1-cycle pulse: violation detected
//  err_code  out  3      code of most recent error, held until next error
//  err_flag  out  1      monitor is in error/resync state
//  seq_cnt   out  CNT_W  completed sequences, saturating
//  err_cnt   out  CNT_W  errors, saturating
// BEHAVIOUR
//  Reset (reset==0 at posedge): FSM=M_IDLE; every output and prev_level = 0.
//  Latency: all outputs registered; LED captured at edge k updates outputs at edge k.
//  Decode: sample legal iff thermometer code (ones contiguous from bit 0); level = popcount.
//  delta = level - prev_level: +1 or -1 is a step; 0 is a hold; anything else is an error.
//  FSM states: M_IDLE, M_UP, M_DOWN, M_ERR.
//   M_IDLE: level 0 holds indefinitely; level 1 -> M_UP, phase 0, start_p.
//   M_UP: +1 continues. -1 legal only if prev_level == peak(phase) -> M_DOWN, phase+1.
//   M_DOWN: -1 continues. +1 legal only if prev_level == trough(phase) -> M_UP, phase+1,
//     or if phase==3 and prev_level==KICK_LVL -> M_UP, phase=2, kick_p.
//   Phase 5 reaching level 0 -> M_IDLE, phase 0, done_p, seq_cnt++ (same edge).
//   Hold rule: in M_UP/M_DOWN a single hold is legal only at a reversal-eligible level
//     (peak, trough or KICK_LVL); a 2nd consecutive hold is an error. Holds in M_IDLE are free.
//  Error codes, lowest wins when several apply: 1 non-thermometer, 2 |delta|>1, 3 illegal hold,
//   4 reversal at wrong peak, 5 reversal at wrong trough, 6 leaving M_IDLE at level >1 (code 6 only when code 2 is absent).
//  On error: err_p, err_code, err_cnt++, FSM -> M_ERR, err_flag=1, busy=0, phase 0.
//  M_ERR: waits for level 0 then -> M_IDLE (next level 1 restarts normally).
//  busy = FSM in M_UP/M_DOWN; dir_up = (FSM==M_UP).
//  Counters saturate at all-ones, never wrap. Reset mid-sequence aborts silently: no err_p, no done_p.
// CONFIGURATION
//  BFLASH_MON_STICKY_ERR_EN defined: M_ERR is terminal until reset; err_flag stays 1,
//   no further err_p/err_cnt increments, err_code frozen at first error.
//  Undefined: M_ERR resyncs at level 0 as above; err_cnt counts every error.
// TESTING
//  T1 reset low 2 clk, LED=0 -> all outputs 0, FSM M_IDLE, err_flag 0.
//  T2 full clean sequence 0->16->6->11->0->6->0, one step per clk -> start_p once,
//     phases 0..5 in order, done_p on final 0, seq_cnt=1, err_cnt=0.
//  T3 phase 3 descent reverses at level 6 -> kick_p, phase=2; climb to 11, fall to 0, finish -> done_p, no error.
//  T4 LED=16'h0005 mid phase 0 -> err_p, err_code=1, err_flag=1; LED=0 then 1 -> new start_p.
//  T5 phase 0 reverses at level 12 -> err_code=4; level jump 3->5 -> err_code=2; two holds at level 9 -> err_code=3.
//  T6 BFLASH_MON_STICKY_ERR_EN: inject error, then clean sequence -> err_flag stays 1,
//     err_cnt=1, no start_p until reset low.

Source files
------------

// File: rtl/bound_flasher_monitor.sv
// Receive-side checker for the 16-LED bound-flasher bus: decodes the lit level and tracks the 6-phase bounce.
// Build option BFLASH_MON_STICKY_ERR_EN makes the error state terminal until reset.
module bound_flasher_monitor #(
  parameter int WIDTH    = 16,
  parameter int PEAK0    = 16,
  parameter int TROUGH1  = 6,
  parameter int PEAK2    = 11,
  parameter int PEAK4    = 6,
  parameter int KICK_LVL = 6,
  parameter int CNT_W    = 8,
  localparam int LW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] LED,
  output logic [LW-1:0]    level,
  output logic [2:0]       phase,
  output logic             dir_up,
  output logic             busy,
  output logic             start_p,
  output logic             done_p,
  output logic             kick_p,
  output logic             err_p,
  output logic [2:0]       err_code,
  output logic             err_flag,
  output logic [CNT_W-1:0] seq_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {M_IDLE, M_UP, M_DOWN, M_ERR} mon_state_t;

  mon_state_t       state_q, state_d;
  logic             hold_q, hold_d;
  logic [2:0]       phase_d;
  logic             start_d, done_d, kick_d, seq_inc;
  logic [2:0]       err_sel;
  logic             err_new;

  logic [LW-1:0]    samp_level;
  logic [WIDTH-1:0] led_inc;
  logic             thermo;
  logic [LW:0]      samp_wide, level_wide;
  logic             step_up, step_dn, is_hold, big_jump;
  logic [LW-1:0]    peak_lvl, trough_lvl;
  logic             kick_ok;

  // level is also the previous sample's level, so every delta is taken against it
  always_comb begin
    samp_level = '0;
    for (int i = 0; i < WIDTH; i++)
      samp_level = samp_level + LW'(LED[i]);
  end

  assign led_inc    = LED + WIDTH'(1);
  assign thermo     = ((LED & led_inc) == '0);
  assign samp_wide  = {1'b0, samp_level};
  assign level_wide = {1'b0, level};
  assign step_up    = (samp_wide == level_wide + (LW+1)'(1));
  assign step_dn    = (level != '0) && (samp_wide == level_wide - (LW+1)'(1));
  assign is_hold    = (samp_level == level);
  assign big_jump   = !(step_up || step_dn || is_hold);

  always_comb begin
    peak_lvl   = '0;
    trough_lvl = '0;
    case (phase)
      3'd0:    peak_lvl   = LW'(PEAK0);
      3'd1:    trough_lvl = LW'(TROUGH1);
      3'd2:    peak_lvl   = LW'(PEAK2);
      3'd4:    peak_lvl   = LW'(PEAK4);
      default: ;
    endcase
  end

  assign kick_ok = (phase == 3'd3) && (level == LW'(KICK_LVL));

  // Next state: errors are ranked so the lowest applicable code is selected
  always_comb begin
    state_d = state_q;
    phase_d = phase;
    hold_d  = hold_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    kick_d  = 1'b0;
    seq_inc = 1'b0;
    err_sel = 3'd0;
    case (state_q)
      M_IDLE: begin
        if (!thermo)
          err_sel = 3'd1;
        else if (big_jump)
          err_sel = 3'd2;
        else if (samp_level == LW'(1)) begin
          state_d = M_UP;
          phase_d = 3'd0;
          hold_d  = 1'b0;
          start_d = 1'b1;
        end else if (samp_level != '0)
          err_sel = 3'd6;
      end
      M_UP: begin
        if (!thermo)
          err_sel = 3'd1;
        else if (big_jump)
          err_sel = 3'd2;
        else if (is_hold) begin
          if (hold_q || (level != peak_lvl))
            err_sel = 3'd3;
          else
            hold_d = 1'b1;
        end else if (step_up)
          hold_d = 1'b0;
        else if (level != peak_lvl)
          err_sel = 3'd4;
        else begin
          state_d = M_DOWN;
          phase_d = phase + 3'd1;
          hold_d  = 1'b0;
        end
      end
      M_DOWN: begin
        if (!thermo)
          err_sel = 3'd1;
        else if (big_jump)
          err_sel = 3'd2;
        else if (is_hold) begin
          if (hold_q || !((level == trough_lvl) || kick_ok))
            err_sel = 3'd3;
          else
            hold_d = 1'b1;
        end else if (step_dn) begin
          hold_d = 1'b0;
          if ((phase == 3'd5) && (samp_level == '0)) begin
            state_d = M_IDLE;
            phase_d = 3'd0;
            done_d  = 1'b1;
            seq_inc = 1'b1;
          end
        end else if (level == trough_lvl) begin
          state_d = M_UP;
          phase_d = phase + 3'd1;
          hold_d  = 1'b0;
        end else if (kick_ok) begin
          state_d = M_UP;
          phase_d = 3'd2;
          hold_d  = 1'b0;
          kick_d  = 1'b1;
        end else
          err_sel = 3'd5;
      end
      M_ERR: begin
`ifdef BFLASH_MON_STICKY_ERR_EN
        state_d = M_ERR;
`else
        if (samp_level == '0)
          state_d = M_IDLE;
`endif
      end
      default: state_d = M_IDLE;
    endcase
    if (err_sel != 3'd0) begin
      state_d = M_ERR;
      phase_d = 3'd0;
      hold_d  = 1'b0;
    end
  end

  assign err_new = (err_sel != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= M_IDLE;
      hold_q   <= 1'b0;
      level    <= '0;
      phase    <= 3'd0;
      start_p  <= 1'b0;
      done_p   <= 1'b0;
      kick_p   <= 1'b0;
      err_p    <= 1'b0;
      err_code <= 3'd0;
      seq_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      level   <= samp_level;
      phase   <= phase_d;
      start_p <= start_d;
      done_p  <= done_d;
      kick_p  <= kick_d;
      err_p   <= err_new;
      if (err_new)
        err_code <= err_sel;
      if (seq_inc && (seq_cnt != '1))
        seq_cnt <= seq_cnt + CNT_W'(1);
      if (err_new && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign busy     = (state_q == M_UP) || (state_q == M_DOWN);
  assign dir_up   = (state_q == M_UP);
  assign err_flag = (state_q == M_ERR);

endmodule
